// File: rtl/ex_stage_ctrl_pkg.sv
// Shared MIPS encodings for the pipeline controllers: opcode/funct constants,
// ALU and MDU operation codes, Tnew values and the E-stage instruction classes.
package ex_stage_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    localparam logic [1:0] TNEW_0   = 2'd0;
    localparam logic [1:0] TNEW_1   = 2'd1;
    localparam logic [1:0] TNEW_2   = 2'd2;

    typedef enum logic [3:0] {
        CL_NONE, CL_R_ALU, CL_I_ALU, CL_LOAD, CL_STORE, CL_JAL, CL_JALR, CL_MFHL, CL_MD
    } iclass_e;

    // Any instruction that reads or writes HI/LO or starts the MDU.
    function automatic logic is_hilo_class(input logic [31:0] instr);
        if (instr[31:26] != OP_RTYPE) return 1'b0;
        case (instr[5:0])
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_stage_ctrl_md_busy_ctr.sv
// Mult/div busy counter: loads the operation length on start and counts down
// to zero; busy while nonzero.
module ex_stage_ctrl_md_busy_ctr #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
    output logic             o_busy
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              r_count <= '0;
        else if (i_start)          r_count <= i_len;
        else if (r_count != '0)    r_count <= r_count - CNT_W'(1);
    end

    assign o_busy = (r_count != '0);

endmodule

// File: rtl/ex_stage_ctrl.sv
// E-stage controller: D->E instruction register, E-stage control decode and
// mult/div issue tracking with the HI/LO stall request back to D.
module ex_stage_ctrl
    import ex_stage_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int RA_W        = 5,
    parameter int ALU_OP_W    = 4,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   instr_d,
    input  logic                stall_i,
    input  logic                flush_i,
    output logic [DATA_W-1:0]   instr_e,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src_imm,
    output logic                is_link,
    output logic [RA_W-1:0]     rf_dst_e,
    output logic [1:0]          tnew_e,
    output logic                md_start,
    output logic [1:0]          md_op,
    output logic                md_busy,
    output logic                md_stall_d
);

    logic [DATA_W-1:0] r_instr_e;
    iclass_e           w_class;
    logic [3:0]        w_alu;
    logic [1:0]        w_md_op;
    logic [5:0]        w_op;
    logic [5:0]        w_fn;
    logic              w_busy;
    logic              w_start;
    logic [CNT_W-1:0]  w_len;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               r_instr_e <= '0;
        else if (stall_i || flush_i) r_instr_e <= '0;
        else                        r_instr_e <= instr_d;
    end

    assign w_op = r_instr_e[31:26];
    assign w_fn = r_instr_e[5:0];

    // The all-zero word is the pipeline bubble; it must not decode as sll.
    always_comb begin
        w_class = CL_NONE;
        w_alu   = ALU_ADD;
        w_md_op = MD_MULT;
        if (r_instr_e != '0) begin
            case (w_op)
                OP_RTYPE: begin
                    case (w_fn)
                        FN_SLL:   begin w_class = CL_R_ALU; w_alu = ALU_SLL;  end
                        FN_SRL:   begin w_class = CL_R_ALU; w_alu = ALU_SRL;  end
                        FN_SRA:   begin w_class = CL_R_ALU; w_alu = ALU_SRA;  end
                        FN_ADDU:  begin w_class = CL_R_ALU; w_alu = ALU_ADD;  end
                        FN_SUBU:  begin w_class = CL_R_ALU; w_alu = ALU_SUB;  end
                        FN_AND:   begin w_class = CL_R_ALU; w_alu = ALU_AND;  end
                        FN_OR:    begin w_class = CL_R_ALU; w_alu = ALU_OR;   end
                        FN_XOR:   begin w_class = CL_R_ALU; w_alu = ALU_XOR;  end
                        FN_NOR:   begin w_class = CL_R_ALU; w_alu = ALU_NOR;  end
                        FN_SLT:   begin w_class = CL_R_ALU; w_alu = ALU_SLT;  end
                        FN_SLTU:  begin w_class = CL_R_ALU; w_alu = ALU_SLTU; end
                        FN_JALR:  w_class = CL_JALR;
                        FN_MFHI, FN_MFLO: w_class = CL_MFHL;
                        FN_MULT:  begin w_class = CL_MD; w_md_op = MD_MULT;  end
                        FN_MULTU: begin w_class = CL_MD; w_md_op = MD_MULTU; end
                        FN_DIV:   begin w_class = CL_MD; w_md_op = MD_DIV;   end
                        FN_DIVU:  begin w_class = CL_MD; w_md_op = MD_DIVU;  end
                        default:  ;
                    endcase
                end
                OP_JAL:            w_class = CL_JAL;
                OP_ADDI, OP_ADDIU: w_class = CL_I_ALU;
                OP_SLTI:  begin w_class = CL_I_ALU; w_alu = ALU_SLT;  end
                OP_SLTIU: begin w_class = CL_I_ALU; w_alu = ALU_SLTU; end
                OP_ANDI:  begin w_class = CL_I_ALU; w_alu = ALU_AND;  end
                OP_ORI:   begin w_class = CL_I_ALU; w_alu = ALU_OR;   end
                OP_XORI:  begin w_class = CL_I_ALU; w_alu = ALU_XOR;  end
                OP_LUI:   begin w_class = CL_I_ALU; w_alu = ALU_LUI;  end
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: w_class = CL_LOAD;
                OP_SB, OP_SH, OP_SW:                 w_class = CL_STORE;
                default: ;
            endcase
        end
    end

    always_comb begin
        alu_src_imm = 1'b0;
        is_link     = 1'b0;
        rf_dst_e    = '0;
        tnew_e      = TNEW_0;
        case (w_class)
            CL_R_ALU, CL_MFHL: begin
                rf_dst_e = RA_W'(r_instr_e[15:11]);
                tnew_e   = TNEW_1;
            end
            CL_JALR: begin
                rf_dst_e = RA_W'(r_instr_e[15:11]);
                tnew_e   = TNEW_1;
                is_link  = 1'b1;
            end
            CL_JAL: begin
                rf_dst_e = RA_W'(31);
                tnew_e   = TNEW_1;
                is_link  = 1'b1;
            end
            CL_I_ALU: begin
                rf_dst_e    = RA_W'(r_instr_e[20:16]);
                tnew_e      = TNEW_1;
                alu_src_imm = 1'b1;
            end
            CL_LOAD: begin
                rf_dst_e    = RA_W'(r_instr_e[20:16]);
                tnew_e      = TNEW_2;
                alu_src_imm = 1'b1;
            end
            CL_STORE: alu_src_imm = 1'b1;
            default:  ;
        endcase
    end

    assign w_start = (w_class == CL_MD) && !w_busy;
    assign w_len   = (w_md_op == MD_DIV || w_md_op == MD_DIVU) ? CNT_W'(DIV_CYCLES)
                                                               : CNT_W'(MULT_CYCLES);

    ex_stage_ctrl_md_busy_ctr #(.CNT_W(CNT_W)) u_md_busy_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (w_start),
        .i_len   (w_len),
        .o_busy  (w_busy)
    );

    assign instr_e    = r_instr_e;
    assign alu_op     = ALU_OP_W'(w_alu);
    assign md_start   = w_start;
    assign md_op      = w_start ? w_md_op : 2'd0;
    assign md_busy    = w_busy;
    assign md_stall_d = is_hilo_class(32'(instr_d)) && (w_start || w_busy);

    // The D-side stall keeps a second MDU op out of E while one is running.
    a_no_issue_while_busy: assert property (@(posedge clk) disable iff (!reset_n)
        !((w_class == CL_MD) && w_busy))
        else $error("MDU op reached E while the MDU is busy");

endmodule
